clockprof: RTL and testbench

Timestamp profiling stage that sits directly downstream of the `clocktime` library function. It consumes `clocktime`'s packed `{command, timestamp}` word. The block pairs START/STOP timestamps into elapsed-cycle intervals and keeps running interval statistics: count, sum, min, max and error count. It returns one result word per accepted command and supports downstream back-pressure through a 2-stage pipeline.

---
 rtl/clockprof.sv | 186 ++++++++++++++++++
 tb/tb_clockprof.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clockprof.sv
// clockprof: pairs START/STOP timestamps from clocktime into intervals and
// keeps running count/sum/min/max/error statistics behind a 2-stage pipeline.
module clockprof #(
    parameter int CMD_WIDTH  = 8,
    parameter int TIME_WIDTH = 64
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic                            ivalid,
    input  logic                            iready,
    output logic                            ovalid,
    output logic                            oready,
    input  logic [CMD_WIDTH+TIME_WIDTH-1:0] idata,
    output logic [TIME_WIDTH-1:0]           odata
);

    typedef enum logic [2:0] {
        CMD_START  = 3'd0,
        CMD_STOP   = 3'd1,
        CMD_RD_N   = 3'd2,
        CMD_RD_SUM = 3'd3,
        CMD_RD_MIN = 3'd4,
        CMD_RD_MAX = 3'd5,
        CMD_RD_ERR = 3'd6,
        CMD_CLEAR  = 3'd7
    } cmd_e;

    localparam logic [TIME_WIDTH-1:0] ONES = {TIME_WIDTH{1'b1}};
    localparam logic [TIME_WIDTH-1:0] ZERO = {TIME_WIDTH{1'b0}};
    localparam logic [TIME_WIDTH-1:0] ONE  = TIME_WIDTH'(1);

    logic                  en;
    cmd_e                  in_cmd;
    logic [TIME_WIDTH-1:0] in_ts;

    // Stage 1: command register plus interval tracking
    logic                  s1_valid_q, s1_valid_d;
    cmd_e                  s1_cmd_q, s1_cmd_d;
    logic [TIME_WIDTH-1:0] s1_val_q, s1_val_d;
    logic                  s1_hit_q, s1_hit_d;
    logic [TIME_WIDTH-1:0] start_ts_q, start_ts_d;
    logic                  armed_q, armed_d;

    // Stage 2: statistics and output register
    logic                  ovalid_q, ovalid_d;
    logic [TIME_WIDTH-1:0] odata_q, odata_d;
    logic [TIME_WIDTH-1:0] n_q, n_d;
    logic [TIME_WIDTH-1:0] sum_q, sum_d;
    logic [TIME_WIDTH-1:0] min_q, min_d;
    logic [TIME_WIDTH-1:0] max_q, max_d;
    logic [TIME_WIDTH-1:0] err_q, err_d;
    logic [TIME_WIDTH:0]   sum_ext;

    assign in_cmd = cmd_e'(idata[TIME_WIDTH+2:TIME_WIDTH]);
    assign in_ts  = idata[TIME_WIDTH-1:0];

    generate
        if (CMD_WIDTH > 3) begin : g_cmd_hi
            logic cmd_hi_unused;
            assign cmd_hi_unused =
                ^idata[CMD_WIDTH+TIME_WIDTH-1:TIME_WIDTH+3];
        end
    endgenerate

    assign en     = ~ovalid_q | iready;
    assign oready = en;
    assign ovalid = ovalid_q;
    assign odata  = odata_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_cmd_d   = s1_cmd_q;
        s1_val_d   = s1_val_q;
        s1_hit_d   = s1_hit_q;
        start_ts_d = start_ts_q;
        armed_d    = armed_q;
        if (en) begin
            s1_valid_d = ivalid;
            if (ivalid) begin
                s1_cmd_d = in_cmd;
                s1_val_d = in_ts;
                s1_hit_d = 1'b0;
                unique case (in_cmd)
                    CMD_START: begin
                        start_ts_d = in_ts;
                        armed_d    = 1'b1;
                    end
                    CMD_STOP: begin
                        // modular subtract handles timestamp wrap
                        s1_val_d = in_ts - start_ts_q;
                        s1_hit_d = armed_q;
                        armed_d  = 1'b0;
                    end
                    CMD_CLEAR: armed_d = 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign sum_ext = {1'b0, sum_q} + {1'b0, s1_val_q};

    always_comb begin
        ovalid_d = ovalid_q;
        odata_d  = odata_q;
        n_d      = n_q;
        sum_d    = sum_q;
        min_d    = min_q;
        max_d    = max_q;
        err_d    = err_q;
        if (en) begin
            ovalid_d = s1_valid_q;
            if (s1_valid_q) begin
                unique case (s1_cmd_q)
                    CMD_START: odata_d = s1_val_q;
                    CMD_STOP: begin
                        if (s1_hit_q) begin
                            odata_d = s1_val_q;
                            n_d     = (n_q == ONES) ? n_q : n_q + ONE;
                            sum_d   = sum_ext[TIME_WIDTH] ? ONES
                                    : sum_ext[TIME_WIDTH-1:0];
                            if (s1_val_q < min_q) min_d = s1_val_q;
                            if (s1_val_q > max_q) max_d = s1_val_q;
                        end else begin
                            odata_d = ONES;
                            err_d   = (err_q == ONES) ? err_q : err_q + ONE;
                        end
                    end
                    CMD_RD_N:   odata_d = n_q;
                    CMD_RD_SUM: odata_d = sum_q;
                    CMD_RD_MIN: odata_d = min_q;
                    CMD_RD_MAX: odata_d = max_q;
                    CMD_RD_ERR: odata_d = err_q;
                    CMD_CLEAR: begin
                        odata_d = ZERO;
                        n_d     = ZERO;
                        sum_d   = ZERO;
                        min_d   = ONES;
                        max_d   = ZERO;
                        err_d   = ZERO;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s1_cmd_q   <= CMD_START;
            s1_val_q   <= ZERO;
            s1_hit_q   <= 1'b0;
            start_ts_q <= ZERO;
            armed_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_cmd_q   <= s1_cmd_d;
            s1_val_q   <= s1_val_d;
            s1_hit_q   <= s1_hit_d;
            start_ts_q <= start_ts_d;
            armed_q    <= armed_d;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ovalid_q <= 1'b0;
            odata_q  <= ZERO;
            n_q      <= ZERO;
            sum_q    <= ZERO;
            min_q    <= ONES;
            max_q    <= ZERO;
            err_q    <= ZERO;
        end else begin
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            n_q      <= n_d;
            sum_q    <= sum_d;
            min_q    <= min_d;
            max_q    <= max_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_clockprof.sv
// Self-checking bench for clockprof: table-driven commands, scoreboard queue,
// back-pressure, reset mid-stream and an 8-bit instance for saturation.
module tb_clockprof;

    typedef struct {
        logic [2:0]  cmd;
        logic [63:0] ts;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] exp;
        int          id;
    } sb_t;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clock = 1'b0;
    logic        resetn;
    logic        ivalid, iready, ovalid, oready;
    logic [71:0] idata;
    logic [63:0] odata;

    logic        ivalid8, iready8, ovalid8, oready8;
    logic [15:0] idata8;
    logic [7:0]  odata8;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          mode = 0;
    int          phase = 0;
    int          next_id = 0;
    bit          lat_req = 0;
    bit          lat_arm = 0;
    int          lat_start = 0;
    bit          stall_q = 0;
    logic [63:0] stall_data;

    sb_t  sbq[$];
    sb_t  sbq8[$];
    vec_t tab[$];
    vec_t bp[$];

    clockprof #(.CMD_WIDTH(8), .TIME_WIDTH(64)) dut (
        .clock (clock),
        .resetn(resetn),
        .ivalid(ivalid),
        .iready(iready),
        .ovalid(ovalid),
        .oready(oready),
        .idata (idata),
        .odata (odata)
    );

    clockprof #(.CMD_WIDTH(8), .TIME_WIDTH(8)) dut8 (
        .clock (clock),
        .resetn(resetn),
        .ivalid(ivalid8),
        .iready(iready8),
        .ovalid(ovalid8),
        .oready(oready8),
        .idata (idata8),
        .odata (odata8)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // downstream ready: 0 = always ready, 1 = random with 3-cycle lows, 2 = stalled
    initial forever begin
        @(negedge clock);
        phase++;
        case (mode)
            1: iready = ((phase % 8) inside {2, 3, 4}) ? 1'b0
                      : ($urandom_range(1, 0) != 0);
            2: iready = 1'b0;
            default: iready = 1'b1;
        endcase
    end

    initial forever begin
        @(negedge clock);
        #3;
        if (!resetn) begin
            stall_q = 0;
        end else begin
            if (stall_q) chk("stall_hold", odata, stall_data);
            stall_q = 0;
            if (ovalid && lat_arm) begin
                chk("latency", 64'(cyc - lat_start), 64'd2);
                lat_arm = 0;
            end
            if (ovalid && !iready) begin
                chk("stall_oready", {63'd0, oready}, 64'd0);
                stall_q    = 1;
                stall_data = odata;
            end
            if (ovalid && iready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none",
                             odata);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    chk($sformatf("result#%0d", e.id), odata, e.exp);
                end
            end
        end
    end

    initial forever begin
        @(negedge clock);
        #3;
        if (resetn && ovalid8) begin
            if (sbq8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output8: got %h expected none",
                         odata8);
            end else begin
                sb_t e;
                e = sbq8.pop_front();
                chk($sformatf("sat#%0d", e.id), {56'd0, odata8}, e.exp);
            end
        end
    end

    task automatic send(input logic [2:0] c, input logic [63:0] ts,
                        input logic [63:0] exp);
        bit ok;
        ok = 0;
        @(negedge clock);
        ivalid = 1'b1;
        idata  = {5'd0, c, ts};
        for (int k = 0; k < 50 && !ok; k++) begin
            #2;
            if (oready) begin
                sbq.push_back('{exp, next_id});
                next_id++;
                ok = 1;
                if (lat_req) begin
                    lat_start = cyc;
                    lat_arm   = 1;
                    lat_req   = 0;
                end
            end else begin
                @(negedge clock);
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got oready=0 expected 1");
        end
    endtask

    task automatic send8(input logic [2:0] c, input logic [7:0] ts,
                         input logic [7:0] exp);
        @(negedge clock);
        ivalid8 = 1'b1;
        idata8  = {5'd0, c, ts};
        #2;
        chk("oready8", {63'd0, oready8}, 64'd1);
        sbq8.push_back('{{56'd0, exp}, next_id});
        next_id++;
    endtask

    task automatic idle();
        @(negedge clock);
        ivalid  = 1'b0;
        ivalid8 = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (sbq.size() == 0 && sbq8.size() == 0) break;
            @(negedge clock);
        end
        chk("drain", 64'(sbq.size() + sbq8.size()), 64'd0);
    endtask

    initial begin
        resetn  = 1'b0;
        ivalid  = 1'b0;
        idata   = '0;
        iready  = 1'b1;
        ivalid8 = 1'b0;
        idata8  = '0;
        iready8 = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_ovalid", {63'd0, ovalid}, 64'd0);
        chk("rst_odata", odata, 64'd0);
        chk("rst_oready", {63'd0, oready}, 64'd1);
        chk("rst_ovalid8", {63'd0, ovalid8}, 64'd0);
        @(negedge clock);
        resetn = 1'b1;

        // basic interval
        tab.push_back('{3'd0, 64'd100, 64'd100});
        tab.push_back('{3'd1, 64'd250, 64'd150});
        tab.push_back('{3'd2, 64'd0, 64'd1});
        tab.push_back('{3'd3, 64'd0, 64'd150});
        // wrap-around and stats
        tab.push_back('{3'd7, 64'd0, 64'd0});
        tab.push_back('{3'd0, ONES - 64'd9, ONES - 64'd9});
        tab.push_back('{3'd1, 64'd5, 64'd15});
        tab.push_back('{3'd0, 64'd0, 64'd0});
        tab.push_back('{3'd1, 64'd40, 64'd40});
        tab.push_back('{3'd4, 64'd0, 64'd15});
        tab.push_back('{3'd5, 64'd0, 64'd40});
        tab.push_back('{3'd3, 64'd0, 64'd55});
        tab.push_back('{3'd2, 64'd0, 64'd2});
        // errors and clear
        tab.push_back('{3'd7, 64'd0, 64'd0});
        tab.push_back('{3'd1, 64'd9, ONES});
        tab.push_back('{3'd6, 64'd0, 64'd1});
        tab.push_back('{3'd7, 64'd0, 64'd0});
        tab.push_back('{3'd4, 64'd0, ONES});
        tab.push_back('{3'd5, 64'd0, 64'd0});
        tab.push_back('{3'd6, 64'd0, 64'd0});
        tab.push_back('{3'd1, 64'd3, ONES});
        tab.push_back('{3'd6, 64'd0, 64'd1});
        // re-START overwrites the start time
        tab.push_back('{3'd0, 64'd10, 64'd10});
        tab.push_back('{3'd0, 64'd20, 64'd20});
        tab.push_back('{3'd1, 64'd25, 64'd5});
        tab.push_back('{3'd2, 64'd0, 64'd1});

        for (int i = 0; i < tab.size(); i++) begin
            if (i == 0) lat_req = 1;
            send(tab[i].cmd, tab[i].ts, tab[i].exp);
        end
        idle();
        drain();

        bp.push_back('{3'd7, 64'd0, 64'd0});
        bp.push_back('{3'd0, 64'd1000, 64'd1000});
        bp.push_back('{3'd1, 64'd1007, 64'd7});
        bp.push_back('{3'd0, 64'd2000, 64'd2000});
        bp.push_back('{3'd1, 64'd2003, 64'd3});
        bp.push_back('{3'd2, 64'd0, 64'd2});
        mode = 1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < bp.size(); i++)
                send(bp[i].cmd, bp[i].ts, bp[i].exp);
            if (r == 1) idle();
        end
        idle();
        drain();

        // reset while both stages hold a command
        mode = 2;
        send(3'd0, 64'd7, 64'd7);
        send(3'd1, 64'd9, 64'd2);
        @(negedge clock);
        ivalid = 1'b0;
        #1;
        chk("pre_rst_ovalid", {63'd0, ovalid}, 64'd1);
        resetn = 1'b0;
        #1;
        chk("async_ovalid", {63'd0, ovalid}, 64'd0);
        chk("async_odata", odata, 64'd0);
        sbq.delete();
        @(negedge clock);
        resetn = 1'b1;
        mode   = 0;
        send(3'd2, 64'd0, 64'd0);
        send(3'd4, 64'd0, ONES);
        send(3'd1, 64'd50, ONES);
        send(3'd6, 64'd0, 64'd1);
        idle();
        drain();

        send8(3'd0, 8'd0, 8'd0);
        send8(3'd1, 8'd200, 8'd200);
        send8(3'd0, 8'd0, 8'd0);
        send8(3'd1, 8'd200, 8'd200);
        send8(3'd3, 8'd0, 8'd255);
        send8(3'd2, 8'd0, 8'd2);
        send8(3'd5, 8'd0, 8'd200);
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
